nibble_serial_add_ctrl: RTL and testbench



---
 rtl/nibble_serial_add_ctrl.sv | 140 ++++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
// Serial WIDTH-bit adder: one 4-bit add slice is reused over WIDTH/4 cycles,
// LSB nibble first, with the inter-nibble carry held in a flop.
// Handshake: i_start is accepted while o_ready=1; o_done pulses for one cycle
// when o_s/o_cout are updated.
// Optional feature macro: NIBBLE_ADD_SUB_EN adds an i_sub port (A - B mode).
module nibble_serial_add_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
`ifdef NIBBLE_ADD_SUB_EN
  input  logic             i_sub,
`endif
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_ready,
  output logic             o_done,
  output logic [WIDTH-1:0] o_s,
  output logic             o_cout
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_part;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_ready;
  logic             r_done;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;

  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [4:0]       w_sum;
  logic [WIDTH-1:0] w_part_next;
  logic             w_last;
  logic [WIDTH-1:0] w_b_cap;
  logic             w_c_cap;

  // Operand values to capture on the accept edge (subtract = A + ~B + 1)
  always_comb begin
`ifdef NIBBLE_ADD_SUB_EN
    w_b_cap = i_sub ? ~i_b : i_b;
    w_c_cap = i_sub ? 1'b1 : i_cin;
`else
    w_b_cap = i_b;
    w_c_cap = i_cin;
`endif
  end

  // Shared 4-bit slice: select current nibble, add, merge into partial sum
  always_comb begin
    w_a_nib     = '0;
    w_b_nib     = '0;
    for (int unsigned n = 0; n < NIB; n++) begin
      if (r_cnt == CW'(n)) begin
        w_a_nib = r_a[4*n +: 4];
        w_b_nib = r_b[4*n +: 4];
      end
    end
    w_sum       = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_carry};
    w_part_next = r_part;
    for (int unsigned n = 0; n < NIB; n++) begin
      if (r_cnt == CW'(n)) begin
        w_part_next[4*n +: 4] = w_sum[3:0];
      end
    end
    w_last      = (r_cnt == CW'(NIB - 1));
  end

  // Sequencer FSM with registered handshake and result outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_part  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_s     <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= w_b_cap;
            r_carry <= w_c_cap;
            r_part  <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_state <= S_RUN;
          end else begin
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_part  <= w_part_next;
          r_carry <= w_sum[4];
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_s     <= w_part_next;
            r_cout  <= w_sum[4];
            r_ready <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_ready <= 1'b1;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_done  = r_done;
  assign o_s     = r_s;
  assign o_cout  = r_cout;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Testbench for nibble_serial_add_ctrl (WIDTH=16). Expected results are queued
// when an operation is issued and checked when o_done pulses.
// The subtract cases build only when NIBBLE_ADD_SUB_EN is defined.
module tb_nibble_serial_add_ctrl;

  localparam int unsigned W   = 16;
  localparam int unsigned NIB = W / 4;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic         cin   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
`ifdef NIBBLE_ADD_SUB_EN
  logic         sub   = 1'b0;
`endif
  logic         o_ready;
  logic         o_done;
  logic [W-1:0] o_s;
  logic         o_cout;

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
`ifdef NIBBLE_ADD_SUB_EN
    .i_sub   (sub),
`endif
    .i_a     (a),
    .i_b     (b),
    .i_cin   (cin),
    .o_ready (o_ready),
    .o_done  (o_done),
    .o_s     (o_s),
    .o_cout  (o_cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         cout;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
  } exp_t;

  exp_t   q[$];
  exp_t   mon_e;
  vec_t   vt[8];
  int     n_tests = 0;
  int     n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: pop and compare whenever the DUT reports completion
  always @(negedge clk) begin
    if (!rst && o_done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = q.pop_front();
        chk("sum",  32'(o_s),    32'(mon_e.s));
        chk("cout", 32'(o_cout), 32'(mon_e.cout));
      end
    end
  end

  // Issue one operation from IDLE and check the handshake timing around it
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input logic [W-1:0] es, input logic ec, input bit ones_in_run);
    logic [W-1:0] ps;
    logic         pc;
    exp_t         e;
    ps = o_s;
    pc = o_cout;
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    e.s = es; e.cout = ec;
    q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < int'(NIB); k++) begin
      a   = ones_in_run ? '1 : W'($urandom);
      b   = ones_in_run ? '1 : W'($urandom);
      cin = 1'($urandom);
      chk("run_ready",  32'(o_ready), 32'd0);
      chk("run_done",   32'(o_done),  32'd0);
      chk("run_s_hold", 32'(o_s),     32'(ps));
      chk("run_c_hold", 32'(o_cout),  32'(pc));
      @(posedge clk); #1;
    end
    chk("done_pulse",   32'(o_done),  32'd1);
    chk("done_ready",   32'(o_ready), 32'd1);
    @(posedge clk); #1;
    chk("done_cleared", 32'(o_done),  32'd0);
    chk("idle_ready",   32'(o_ready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ta, tbv;
    logic         tc;
    logic [W:0]   s17;
    int           last_done, ndone;

    vt[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vt[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vt[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vt[4] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vt[5] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0};
    vt[6] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
    vt[7] = '{16'h0F0F, 16'h0F0F, 1'b1, 16'h1E1F, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_done",  32'(o_done),  32'd0);
    chk("rst_s",     32'(o_s),     32'd0);
    chk("rst_cout",  32'(o_cout),  32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++)
      run_op(vt[i].a, vt[i].b, vt[i].cin, vt[i].s, vt[i].cout, 1'b0);

    for (int i = 0; i < 6; i++) begin
      ta  = W'($urandom);
      tbv = W'($urandom);
      tc  = 1'($urandom);
      s17 = {1'b0, ta} + {1'b0, tbv} + (W+1)'(tc);
      run_op(ta, tbv, tc, s17[W-1:0], s17[W], 1'b0);
    end

    // Operands forced to all-ones after acceptance must not matter
    run_op(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b1);

    // Start held high: back-to-back ops, Start during RUN ignored
    last_done = -1;
    ndone     = 0;
    cin       = 1'b0;
    start     = 1'b1;
    for (int c = 0; c < 3 * int'(NIB + 1); c++) begin
      if (o_ready) begin
        exp_t e;
        a = 16'h0001; b = 16'h0001;
        e.s = 16'h0002; e.cout = 1'b0;
        q.push_back(e);
      end else begin
        a = W'($urandom); b = W'($urandom);
      end
      @(posedge clk); #1;
      if (o_done) begin
        if (last_done >= 0) chk("done_period", 32'(c - last_done), 32'(NIB + 1));
        last_done = c;
        ndone++;
      end
    end
    start = 1'b0;
    chk("b2b_done_count", 32'(ndone), 32'd3);
    @(posedge clk); #1;
    chk("b2b_idle_ready", 32'(o_ready), 32'd1);

    // Asynchronous reset in the middle of RUN
    run_op(16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0);
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b1;
    q.delete();
    #1;
    chk("arst_s",     32'(o_s),     32'd0);
    chk("arst_cout",  32'(o_cout),  32'd0);
    chk("arst_ready", 32'(o_ready), 32'd1);
    chk("arst_done",  32'(o_done),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < int'(NIB + 2); c++) begin
      @(posedge clk); #1;
      chk("arst_no_done", 32'(o_done), 32'd0);
    end
    run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

`ifdef NIBBLE_ADD_SUB_EN
    sub = 1'b1;
    run_op(16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    run_op(16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b1, 1'b0);
    run_op(16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0);
    sub = 1'b0;
    run_op(16'h0005, 16'h0007, 1'b1, 16'h000D, 1'b0, 1'b0);
`endif

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
